uart_cmd_ctrl: RTL
==================

# uart_cmd_ctrl

Command controller that sits between the board's `uart_rx` (115200 bps) and a `uart_tx` instance. It parses framed commands from the host and owns the four board LEDs, choosing between a free-running chaser pattern and host-set manual values. It answers every complete frame with a 2-byte ACK/NAK response through the transmitter handshake. It also keeps a saturating protocol-error counter for bring-up diagnostics.

## Interface

Parameters:
- `CHASE_BITS`, default 23: chaser advances one step every 2^CHASE_BITS clocks.
- `TIMEOUT_CYCLES`, default 5_000_000: maximum inter-byte gap inside a frame (100 ms at 50 MHz).

Ports:
- `clk_50M`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_dv`  in  1  one-cycle strobe from `uart_rx`: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `tx_busy`  in  1  `uart_tx` active flag; high for the whole transmission, rising the cycle after `tx_start`.
- `tx_start`  out  1  one-cycle request to transmit `tx_byte`.
- `tx_byte`  out  8  byte to transmit; held stable until `tx_busy` rises.
- `leds`  out  4  LED drive; bit 0 is led110 … bit 3 is led115.
- `led_mode`  out  1  0 = chaser, 1 = manual.
- `err_count`  out  8  protocol-error count; saturates at 255.

## Operation

- **Frame format:** 0xA5, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- **Commands:**
  - 0x01: set manual; `leds` ← ARG[3:0], `led_mode` ← 1.
  - 0x02: chaser mode; `led_mode` ← 0, ARG ignored.
  - 0x03: status read; no state change.
- **Response for a valid frame:** 0x06, then STATUS = {`led_mode`, 3'b000, `leds`}. STATUS reflects the values after the command has taken effect.
- **NAK response:** 0x15, then an error code; `err_count` increments by 1.
  - Code 0x01: bad checksum. Checksum is checked first.
  - Code 0x02: unknown CMD with a good checksum.
- **State machine:**
  - S_SYNC: wait for 0xA5; other bytes are discarded silently with no count.
  - S_CMD, S_ARG, S_CHK: capture one byte each, advancing on `rx_dv`.
  - S_EXEC: one cycle; validate the frame and apply the command.
  - S_TX0: first response byte.
  - S_TX1: second response byte.
  - Then return to S_SYNC.
- **Per transmit state (handshake):**
  1. Wait for `tx_busy` = 0.
  2. Pulse `tx_start` for 1 cycle with `tx_byte` loaded.
  3. Wait for `tx_busy` = 1, then for `tx_busy` = 0.
- **Bytes arriving during S_EXEC/S_TX0/S_TX1:** `rx_dv` is ignored and the bytes are dropped.
- **Inter-byte timeout:**
  - A counter runs in S_CMD/S_ARG/S_CHK and clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES: go to S_SYNC, increment `err_count`, send no response.
  - A 0xA5 arriving in the same cycle as the timeout is treated as a new sync byte and the next state is S_CMD.
- **Chaser:**
  - A free-running (CHASE_BITS+3)-bit counter; its top 3 bits select the pattern 1000, 0100, 0010, 0001, 0001, 0010, 0100, 1000.
  - The counter wraps naturally and runs in both modes.
  - In chaser mode, `leds` shows the pattern registered from the counter.
- **`err_count`:** saturating 8-bit; 255 + 1 stays 255.
- **Reset values:** state S_SYNC, `leds` 4'b0000, `led_mode` 0, `tx_start` 0, `tx_byte` 0x00, `err_count` 0, chaser counter 0, timeout counter 0.
- **Reset mid-operation:** reset mid-frame or mid-response aborts the transaction immediately. No further `tx_start` is issued.

## Timing

- **CHK accepted at edge N** (`rx_dv` high in the preceding cycle):
  - State is S_EXEC in cycle N..N+1.
  - `leds`/`led_mode` take their new values at edge N+1.
  - `tx_start` for the first byte is at the earliest in cycle N+1..N+2, i.e. registered high after edge N+1, if `tx_busy` = 0.
- **Second `tx_start`:** no earlier than 1 cycle after `tx_busy` falls from the first byte.
- **`tx_start`:** never high for 2 consecutive cycles, and never high while `tx_busy` = 1.
- **Chaser in chaser mode:** `leds` changes only on counter-step boundaries, with a 1-cycle register delay.
- **Throughput:** the next frame may begin on the byte after the second response byte is accepted. No frame overlap.

## Test plan

- **Reset:** hold `rst_n` low for 5 cycles → all outputs at their reset values. Release with CHASE_BITS=2 → `leds` steps 1000 (first step), 0100, 0010, 0001, 0001, 0010, 0100, 1000 every 4 clocks, then wraps.
- **Set manual:** frame A5 01 0B 0A → `leds`=4'b1011, `led_mode`=1. TX emits 0x06, then 0x8B. Two `tx_start` pulses, each only while `tx_busy`=0.
- **Bad checksum:** frame A5 01 0F 00 → NAK: 0x15 then 0x01, `err_count`=1, `leds` unchanged. Unknown command A5 07 00 07 → 0x15 then 0x02, `err_count`=2.
- **Timeout:** with TIMEOUT_CYCLES=100, send A5 03 and then idle 100 cycles → back to S_SYNC, `err_count`+1, no TX. A subsequent A5 03 00 03 → 0x06, then STATUS.
- **Busy TX and dropped bytes:** after a valid frame, `tx_busy` is held high 50 cycles → no `tx_start` until it falls. Extra bytes sent during the response are dropped. Garbage 0x11 0x22 in S_SYNC → ignored, `err_count` unchanged.
- **Saturation and mid-frame reset:** 260 bad-checksum frames → `err_count`=255. Then assert `rst_n` low mid-response → `tx_start` stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Parses framed host commands (0xA5, CMD, ARG, CHK with CHK = CMD ^ ARG)
// received from a uart_rx, drives the four board LEDs in either chaser or
// manual mode, and answers every complete frame with a two-byte ACK/NAK
// response through the uart_tx start/busy handshake. A saturating 8-bit
// counter records protocol errors (bad checksum, unknown command, timeout).
//
// Ports:
//   clk_50M    in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   rx_dv      in   1  one-cycle strobe, rx_byte valid
//   rx_byte    in   8  received byte
//   tx_busy    in   1  transmitter active (rises the cycle after tx_start)
//   tx_start   out  1  one-cycle transmit request
//   tx_byte    out  8  byte to transmit, stable until tx_busy rises
//   leds       out  4  LED drive (bit 0 = led110 ... bit 3 = led115)
//   led_mode   out  1  0 = chaser, 1 = manual
//   err_count  out  8  saturating protocol-error count
module uart_cmd_ctrl #(
  parameter int CHASE_BITS     = 23,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic [3:0] leds,
  output logic       led_mode,
  output logic [7:0] err_count
);

  localparam int CW   = CHASE_BITS + 3;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds TIMEOUT_CYCLES-1 in the last cycle before it would
  // reach TIMEOUT_CYCLES, so the abort happens on that cycle's edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] ERR_CHK   = 8'h01;
  localparam logic [7:0] ERR_CMD   = 8'h02;

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_ARG,
    S_CHK,
    S_EXEC,
    S_TX0,
    S_TX1
  } state_t;

  // Handshake sub-phase shared by S_TX0 and S_TX1.
  typedef enum logic [1:0] {
    P_IDLE,   // waiting for the transmitter to be free
    P_ACK,    // start issued, waiting for tx_busy to rise
    P_DONE    // waiting for tx_busy to fall
  } phase_t;

  state_t          state_reg, state_next;
  phase_t          phase_reg, phase_next;
  logic [7:0]      cmd_reg, cmd_next;
  logic [7:0]      arg_reg, arg_next;
  logic [7:0]      chk_reg, chk_next;
  logic [7:0]      resp1_reg, resp1_next;
  logic [CW-1:0]   chase_cnt_reg, chase_cnt_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            tx_start_reg, tx_start_next;
  logic [7:0]      tx_byte_reg, tx_byte_next;
  logic [3:0]      leds_reg, leds_next;
  logic            led_mode_reg, led_mode_next;
  logic [7:0]      err_count_reg, err_count_next;

  logic [3:0]      pattern;
  logic            err_inc;
  logic            chk_ok;
  logic            cmd_known;

  // Bounce pattern selected by the top three bits of the chaser counter.
  always_comb begin
    pattern = 4'b1000;
    case (chase_cnt_reg[CW-1 -: 3])
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b0100;
      3'd2:    pattern = 4'b0010;
      3'd3:    pattern = 4'b0001;
      3'd4:    pattern = 4'b0001;
      3'd5:    pattern = 4'b0010;
      3'd6:    pattern = 4'b0100;
      default: pattern = 4'b1000;
    endcase
  end

  assign chk_ok    = ((cmd_reg ^ arg_reg) == chk_reg);
  assign cmd_known = (cmd_reg == 8'h01) || (cmd_reg == 8'h02) || (cmd_reg == 8'h03);

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    cmd_next       = cmd_reg;
    arg_next       = arg_reg;
    chk_next       = chk_reg;
    resp1_next     = resp1_reg;
    to_cnt_next    = '0;
    chase_cnt_next = chase_cnt_reg + CW'(1);
    tx_start_next  = 1'b0;
    tx_byte_next   = tx_byte_reg;
    led_mode_next  = led_mode_reg;
    leds_next      = led_mode_reg ? leds_reg : pattern;
    err_inc        = 1'b0;

    case (state_reg)
      S_SYNC: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          state_next = S_CMD;
        end
      end

      S_CMD, S_ARG, S_CHK: begin
        if (to_cnt_reg == TO_LAST) begin
          // Timeout wins over a byte in the same cycle, except that a sync
          // byte is taken as the start of a fresh frame.
          err_inc    = 1'b1;
          state_next = (rx_dv && (rx_byte == SYNC_BYTE)) ? S_CMD : S_SYNC;
        end else if (rx_dv) begin
          case (state_reg)
            S_CMD: begin
              cmd_next   = rx_byte;
              state_next = S_ARG;
            end
            S_ARG: begin
              arg_next   = rx_byte;
              state_next = S_CHK;
            end
            default: begin
              chk_next   = rx_byte;
              state_next = S_EXEC;
            end
          endcase
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      S_EXEC: begin
        if (!chk_ok) begin
          tx_byte_next = NAK_BYTE;
          resp1_next   = ERR_CHK;
          err_inc      = 1'b1;
        end else if (!cmd_known) begin
          tx_byte_next = NAK_BYTE;
          resp1_next   = ERR_CMD;
          err_inc      = 1'b1;
        end else begin
          if (cmd_reg == 8'h01) begin
            led_mode_next = 1'b1;
            leds_next     = arg_reg[3:0];
          end else if (cmd_reg == 8'h02) begin
            led_mode_next = 1'b0;
            leds_next     = pattern;
          end
          tx_byte_next = ACK_BYTE;
          // Status reports the values being registered on this same edge.
          resp1_next   = {led_mode_next, 3'b000, leds_next};
        end
        state_next = S_TX0;
        // Launch the first byte straight away when the transmitter is free.
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          phase_next    = P_ACK;
        end else begin
          phase_next    = P_IDLE;
        end
      end

      S_TX0, S_TX1: begin
        case (phase_reg)
          P_IDLE: begin
            if (!tx_busy) begin
              tx_start_next = 1'b1;
              phase_next    = P_ACK;
            end
          end
          P_ACK: begin
            if (tx_busy) begin
              phase_next = P_DONE;
            end
          end
          P_DONE: begin
            if (!tx_busy) begin
              phase_next = P_IDLE;
              if (state_reg == S_TX0) begin
                state_next   = S_TX1;
                tx_byte_next = resp1_reg;
              end else begin
                state_next   = S_SYNC;
              end
            end
          end
          default: phase_next = P_IDLE;
        endcase
      end

      default: state_next = S_SYNC;
    endcase

    err_count_next = (err_inc && (err_count_reg != 8'hFF)) ?
                     (err_count_reg + 8'd1) : err_count_reg;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_SYNC;
      phase_reg     <= P_IDLE;
      cmd_reg       <= '0;
      arg_reg       <= '0;
      chk_reg       <= '0;
      resp1_reg     <= '0;
      chase_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      tx_start_reg  <= 1'b0;
      tx_byte_reg   <= '0;
      leds_reg      <= '0;
      led_mode_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cmd_reg       <= cmd_next;
      arg_reg       <= arg_next;
      chk_reg       <= chk_next;
      resp1_reg     <= resp1_next;
      chase_cnt_reg <= chase_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      tx_start_reg  <= tx_start_next;
      tx_byte_reg   <= tx_byte_next;
      leds_reg      <= leds_next;
      led_mode_reg  <= led_mode_next;
      err_count_reg <= err_count_next;
    end
  end

  assign tx_start  = tx_start_reg;
  assign tx_byte   = tx_byte_reg;
  assign leds      = leds_reg;
  assign led_mode  = led_mode_reg;
  assign err_count = err_count_reg;

endmodule
